// File: rtl/fifo_pkg.sv
// Shared sizing helpers and read-mode encodings for the sync_fifo_ext family.
package fifo_pkg;

    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    function automatic int ptr_width(input int depth);
        return ($clog2(depth) < 1) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: one write port, one read port that is either
// registered (with reset/hold) or asynchronous, chosen by REG_READ.
module fifo_mem #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int AW       = 3,
    parameter int REG_READ = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (reset) begin
            rdata_d = '0;
        end else if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
    end

    assign rdata = (REG_READ != 0) ? rdata_q : mem_q[raddr];

endmodule

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with count-based full/empty, programmable almost flags,
// overflow/underflow pulses and optional first-word-fall-through reads.
module sync_fifo_ext
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int FWFT     = FWFT_OFF,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       write_en,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       read_en,
    output logic [WIDTH-1:0]           data_out,
    output logic                       data_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          dv_q, dv_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          wr_acc, rd_acc;
    logic [WIDTH-1:0] mem_rdata;

    assign full         = (count_q == CNT_FULL);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign count        = count_q;

    assign wr_acc = write_en & ~full;
    assign rd_acc = read_en & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dv_d     = 1'b0;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        if (reset) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Explicit wrap keeps non-power-of-two depths correct.
            if (wr_acc) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            dv_d  = rd_acc;
            ovf_d = write_en & full;
            unf_d = read_en & empty;
        end
    end

    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
        dv_q     <= dv_d;
        ovf_q    <= ovf_d;
        unf_q    <= unf_d;
    end

    fifo_mem #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AW       (PW),
        .REG_READ ((FWFT == FWFT_ON) ? 0 : 1)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (wr_acc & ~reset),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .re    (rd_acc),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    assign data_out   = mem_rdata;
    assign data_valid = (FWFT == FWFT_ON) ? ~empty : dv_q;
    assign overflow   = ovf_q;
    assign underflow  = unf_q;

endmodule

// File: doc/sync_fifo_ext.md
Name: sync_fifo_ext

Overview:
Parametrised synchronous single-clock FIFO. It is the next-generation buffer for the lab datapaths.
- Every one of the DEPTH entries is usable; full/empty are count-based, with no sacrificial slot.
- Provides an occupancy count, programmable almost-full/almost-empty thresholds, overflow/underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between a producer and a consumer in the same clock domain.

Parameters:
WIDTH, 32, data word width in bits (>=1)
DEPTH, 8, number of storage entries (>=2, any integer; pointers wrap explicitly at DEPTH-1)
FWFT, 0, 0 = standard mode (registered read, 1-cycle latency); 1 = head word presented on data_out while not empty
AF_LEVEL, DEPTH-1, almost_full asserted when count >= AF_LEVEL
AE_LEVEL, 1, almost_empty asserted when count <= AE_LEVEL

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high
write_en  in  1  write request
data_in  in  WIDTH  write data
read_en  in  1  read request (in FWFT mode: acknowledge/pop of head word)
data_out  out  WIDTH  read data
data_valid  out  1  standard mode: data_out updated this cycle; FWFT mode: equals !empty
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
overflow  out  1  one-cycle pulse: write_en while full
underflow  out  1  one-cycle pulse: read_en while empty

Behaviour:
- Reset (synchronous, active-high): pointers = 0, count = 0, data_out = 0, data_valid = 0, overflow = underflow = 0.
  - Status after reset: empty = 1, full = 0, almost_empty = 1, almost_full = (AF_LEVEL == 0).
  - Memory contents are not cleared.
  - Reset has priority over all requests in the same cycle. Reset mid-stream discards all stored data.
- Acceptance uses the registered state at the clock edge:
  - write accepted = write_en & !full
  - read accepted = read_en & !empty
- Both accepted in the same cycle: count unchanged, both pointers advance.
- Full and both requested: read accepted, write rejected, overflow pulses.
- Empty and both requested: write accepted, read rejected, underflow pulses. No bypass of data_in to data_out.
- Pointer wrap: a pointer equal to DEPTH-1 goes to 0 on increment; correct for non-power-of-two DEPTH.
- count: +1 on write-only, -1 on read-only, otherwise held. It never exceeds DEPTH or goes below 0.
- All flags are combinational from count, so they are valid in the cycle after the causing edge.
- Standard mode (FWFT=0):
  - On an accepted read, data_out <= mem[rd_ptr] and data_valid = 1 for exactly that following cycle.
  - Otherwise data_out holds its last value and data_valid = 0.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] continuously; data_valid = !empty.
  - A word written at edge N is visible on data_out after edge N if the FIFO was empty.
  - An accepted read advances to the next word after the edge.
  - data_out is don't-care while empty.
- overflow/underflow are registered pulses, high for the one cycle after the offending edge. Rejected requests leave no other side effect.

Decomposition:
- Shared package fifo_pkg:
  - function returning pointer width, max(1, $clog2(DEPTH))
  - function returning count width, $clog2(DEPTH+1)
  - localparams for the mode encodings FWFT_OFF/FWFT_ON
- One sub-module, fifo_mem: simple dual-port array with one write port and one read port.
  - Read port is selectable registered or asynchronous via a parameter, driven by FWFT.
- Pointer/count/flag control stays in sync_fifo_ext.

Test Plan:
1. DEPTH=8, FWFT=0: write 0xA0..0xA7 -> full=1, count=8 after 8th edge. 9th write -> overflow pulse, count stays 8. Read 8 -> data_out 0xA0..0xA7 in order, each with a data_valid pulse; empty=1.
2. DEPTH=5: 3 rounds of write-5/read-5 with data 1..15 -> order preserved across pointer wrap at index 4, count returns to 0 each round.
3. Simultaneous write/read at count=3 -> count stays 3. At count=5 (full, DEPTH=5) -> read accepted, write dropped, overflow=1, count=4. At count=0 -> write accepted, underflow=1, count=1.
4. FWFT=1: write 0x55 into empty -> next cycle data_out=0x55, data_valid=1, no read issued. read_en -> empty=1, data_valid=0.
5. AF_LEVEL=6, AE_LEVEL=2, DEPTH=8: fill 0->8 then drain -> almost_empty deasserts at count 3, almost_full asserts at count 6, mirrored on drain.
6. Reset asserted at count=4 during simultaneous read/write -> next cycle count=0, empty=1, data_out=0, data_valid=0. Subsequent write/read of 0x12 returns 0x12.
